// File: rtl/mealy_compl2.sv
// rtl/mealy_compl2.sv - bit-serial two's-complement negator, LSB first, Mealy output
module mealy_compl2 (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   typedef enum logic {
      S_COPY = 1'b0,
      S_INV  = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   // Copy bits through the first 1, invert everything after it.
   always_comb begin
      state_d = state_q;
      if (state_q == S_COPY && in) begin
         state_d = S_INV;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_COPY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      out = 1'b0;
      if (!rst) begin
         out = (state_q == S_INV) ? ~in : in;
      end
   end

endmodule

// File: tb/tb_mealy_compl2.sv
// tb/tb_mealy_compl2.sv - directed self-checking bench for mealy_compl2
module tb_mealy_compl2;

   logic clk;
   logic rst;
   logic in;
   logic out;

   int pass_cnt;
   int total_cnt;

   mealy_compl2 dut (
      .clk (clk),
      .rst (rst),
      .in  (in),
      .out (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hold rst for one cycle with the given in value; out must read 0 meanwhile.
   task automatic do_reset(input logic rst_in, input string name);
      rst = 1'b1;
      in  = rst_in;
      @(negedge clk);
      total_cnt++;
      if (out !== 1'b0) begin
         $display("FAIL %s: out=%b expected 0", name, out);
      end else begin
         pass_cnt++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic feed_word(input logic [7:0] w, input int n, output logic [7:0] o);
      o = 8'h00;
      for (int i = 0; i < n; i++) begin
         in = w[i];
         @(negedge clk);
         o[i] = out;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_word(input string name, input logic [7:0] got, input logic [7:0] exp);
      total_cnt++;
      if (got !== exp) begin
         $display("FAIL %s: out=%b expected %b", name, got, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic test_reset();
      logic [7:0] o;
      do_reset(1'b0, "reset_out_in0");
      do_reset(1'b1, "reset_out_in1");
      feed_word(8'h01, 1, o);
      check_word("first_bit_after_reset", o, 8'h01);
   endtask

   task automatic test_basic();
      logic [7:0] o;
      do_reset(1'b0, "basic_reset");
      feed_word(8'b0011_0110, 8, o);
      check_word("neg_0x36", o, 8'b1100_1010);
   endtask

   task automatic test_zero();
      logic [7:0] o;
      do_reset(1'b0, "zero_reset");
      feed_word(8'h00, 8, o);
      check_word("neg_zero", o, 8'h00);
      // Still in S_COPY, so a following 1 passes straight through.
      feed_word(8'h01, 1, o);
      check_word("zero_stays_copy", o, 8'h01);
   endtask

   task automatic test_most_negative();
      logic [7:0] o;
      do_reset(1'b0, "mneg_reset");
      feed_word(8'b1000_0000, 8, o);
      check_word("neg_0x80", o, 8'b1000_0000);
      // Bit 7 moved the FSM into S_INV, so a following 0 comes out as 1.
      feed_word(8'h00, 1, o);
      check_word("mneg_entered_inv", o, 8'h01);
   endtask

   task automatic test_lsb_one();
      logic [7:0] o;
      do_reset(1'b0, "lsb1_reset");
      feed_word(8'h01, 8, o);
      check_word("neg_0x01", o, 8'hFF);
      do_reset(1'b0, "ff_reset");
      feed_word(8'hFF, 8, o);
      check_word("neg_0xFF", o, 8'h01);
   endtask

   task automatic test_mid_reset();
      logic [7:0] o;
      do_reset(1'b0, "mid_pre_reset");
      feed_word(8'b0011_0110, 4, o);
      check_word("mid_partial", o, 8'b0000_1010);
      do_reset(1'b1, "mid_reset_out");
      feed_word(8'b0000_0100, 4, o);
      check_word("mid_after_reset", o, 8'b0000_1100);
   endtask

   task automatic test_back_to_back();
      logic [7:0] o;
      do_reset(1'b0, "b2b_reset");
      feed_word(8'h02, 8, o);
      check_word("b2b_first", o, 8'hFE);
      feed_word(8'h00, 8, o);
      check_word("b2b_second_sticky", o, 8'hFF);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst = 1'b1;
      in  = 1'b0;
      test_reset();
      test_basic();
      test_zero();
      test_most_negative();
      test_lsb_one();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
